dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accept, wait LATENCY cycles,
// perform the access and pulse resp_valid for one cycle. Storage is split into byte lanes.

module dmem_byte_lane #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        addr_err,
    output logic        stall
);
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic                          is_write;
        logic                          fault;
        logic [ADDR_W-1:0]             word;
        logic [NUM_LANES-1:0][7:0]     wdata;
        logic [NUM_LANES-1:0]          be;
    } req_t;

    logic [1:0]                state;
    logic [CNT_W-1:0]          cnt;
    req_t                      req_q;
    logic                      req_fault;
    logic                      do_access;
    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] lane_rdata;

    // Misaligned or beyond the array: anything set above the word-index bits.
    assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);
    assign do_access = (state == BUSY) && (cnt == '0);

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign lane_we[i] = do_access && req_q.is_write && !req_q.fault && req_q.be[i];
            dmem_byte_lane #(
                .DEPTH_WORDS(DEPTH_WORDS),
                .ADDR_W     (ADDR_W)
            ) u_lane (
                .clock(clock),
                .we   (lane_we[i]),
                .addr (req_q.word),
                .wdata(req_q.wdata[i]),
                .rdata(lane_rdata[i])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        req_q.is_write <= req_write;
                        req_q.fault    <= req_fault;
                        req_q.word     <= req_addr[ADDR_W+1:2];
                        req_q.wdata    <= req_wdata;
                        req_q.be       <= req_be;
                        cnt            <= CNT_W'(LATENCY - 1);
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RESP;
                        // Only loads touch rdata; stores leave the last load result visible.
                        if (!req_q.is_write) rdata <= req_q.fault ? 32'd0 : lane_rdata;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign addr_err   = (state == RESP) && req_q.fault;

    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state)
                IDLE:    stall = req_read | req_write;
                BUSY:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic on a LATENCY=2
// and a LATENCY=1 instance, checked against a word-array reference model.

module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rd_i  [2];
    logic        wr_i  [2];
    logic [31:0] addr_i[2];
    logic [31:0] wd_i  [2];
    logic [3:0]  be_i  [2];
    logic [31:0] rdata_o[2];
    logic        rv_o  [2];
    logic        ae_o  [2];
    logic        st_o  [2];

    int          tests = 0;
    int          fails = 0;
    int          lat[2];
    logic [31:0] mm[2][256];
    logic [31:0] exp_rdata[2];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_read(rd_i[0]), .req_write(wr_i[0]), .req_addr(addr_i[0]),
        .req_wdata(wd_i[0]), .req_be(be_i[0]),
        .rdata(rdata_o[0]), .resp_valid(rv_o[0]), .addr_err(ae_o[0]), .stall(st_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_read(rd_i[1]), .req_write(wr_i[1]), .req_addr(addr_i[1]),
        .req_wdata(wd_i[1]), .req_be(be_i[1]),
        .rdata(rdata_o[1]), .resp_valid(rv_o[1]), .addr_err(ae_o[1]), .stall(st_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request (caller is just after a posedge, DUT idle) and checks
    // stall length, response timing, addr_err and rdata against the model.
    task automatic access(input int s, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        logic        fault;
        logic        got;
        int          n_stall;
        int          cyc;
        int          w;
        logic [31:0] m;
        fault = (a[1:0] != 2'b00) || (a >= 32'd1024);
        w     = int'(a[9:2]);
        if (wr) begin
            if (!fault) begin
                m = mm[s][w];
                for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
                mm[s][w] = m;
            end
        end else begin
            exp_rdata[s] = fault ? 32'd0 : mm[s][w];
        end
        rd_i[s] = rd; wr_i[s] = wr; addr_i[s] = a; wd_i[s] = wd; be_i[s] = be;
        got = 1'b0; n_stall = 0; cyc = 0;
        for (int c = 0; c < 16 && !got; c++) begin
            @(negedge clock);
            cyc++;
            if (rv_o[s]) begin
                got = 1'b1;
                chk("resp_stall", 32'(st_o[s]), 32'd0);
                chk("addr_err", 32'(ae_o[s]), 32'(fault));
                chk("rdata", rdata_o[s], exp_rdata[s]);
            end else if (st_o[s]) begin
                n_stall++;
            end
            @(posedge clock); #1;
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("stall_cycles", n_stall, lat[s] + 1);
        chk("access_cycles", cyc, lat[s] + 2);
    endtask

    // Drop the request after RESP and confirm the held request was not re-accepted.
    task automatic idle(input int s);
        rd_i[s] = 1'b0; wr_i[s] = 1'b0;
        @(negedge clock);
        chk("idle_stall", 32'(st_o[s]), 32'd0);
        chk("idle_resp", 32'(rv_o[s]), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic random_traffic(input int s, input int n);
        int          w;
        int          kind;
        int          op;
        logic [31:0] a;
        for (int k = 0; k < 8; k++) access(s, 1'b0, 1'b1, 32'(k * 4), $urandom, 4'hF);
        for (int k = 0; k < n; k++) begin
            w    = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 2);
            if (kind == 0)      a = 32'(w * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = 32'(w * 4) | (32'($urandom_range(1, 255)) << 10);
            else                a = 32'(w * 4);
            access(s, op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(s);
        end
        idle(s);
    endtask

    initial begin
        lat[0] = 2; lat[1] = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        for (int s = 0; s < 2; s++) begin
            rd_i[s] = 1'b1; wr_i[s] = 1'b0; addr_i[s] = '0; wd_i[s] = '0; be_i[s] = '0;
        end
        // Reset held with a request pending: stall must stay low.
        @(negedge clock); @(negedge clock);
        chk("rst_stall", 32'(st_o[0]), 32'd0);
        chk("rst_rdata", rdata_o[0], 32'd0);
        chk("rst_resp", 32'(rv_o[0]), 32'd0);
        chk("rst_aerr", 32'(ae_o[0]), 32'd0);
        rd_i[0] = 1'b0; rd_i[1] = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;

        access(0, 1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("load_cafe", rdata_o[0], 32'hCAFEBABE);
        idle(0);

        access(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        access(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("be_merge", rdata_o[0], 32'h11BB33DD);
        idle(0);

        access(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
        access(0, 1'b1, 1'b0, 32'h21, 32'h0, 4'h0);
        access(0, 1'b0, 1'b1, 32'h400, 32'hDEADDEAD, 4'hF);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("oob_no_alias", rdata_o[0], 32'h0BADF00D);
        idle(0);

        access(0, 1'b1, 1'b1, 32'h30, 32'h5, 4'hF);
        chk("both_keeps_rdata", rdata_o[0], 32'h0BADF00D);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        idle(0);

        // Reset in the middle of BUSY for a store: it must be abandoned.
        access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF);
        idle(0);
        rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 32'h40; wd_i[0] = 32'hFFFFFFFF; be_i[0] = 4'hF;
        @(posedge clock); #1;
        chk("busy_stall", 32'(st_o[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(st_o[0]), 32'd0);
        chk("mid_rst_rdata", rdata_o[0], 32'd0);
        chk("mid_rst_resp", 32'(rv_o[0]), 32'd0);
        wr_i[0] = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        chk("rst_preserve", rdata_o[0], 32'h12345678);

        // Back-to-back loads with no idle gap.
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        idle(0);

        access(1, 1'b0, 1'b1, 32'h10, 32'h600DCAFE, 4'hF);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("lat1_load", rdata_o[1], 32'h600DCAFE);
        idle(1);

        random_traffic(0, 60);
        random_traffic(1, 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
